stack_port_ctrl: RTL and testbench

STACK_PORT_CTRL -- requirements
Module: stack_port_ctrl

---
 rtl/stack_port_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stack_port_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_port_ctrl.sv
// Stack port controller: push/pop/load-esp commands against a 32-word synchronous-read stack memory.
// Build option STACK_GUARD_EN enables overflow/underflow/bad-load fault detection.
module stack_port_ctrl #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ESP_RESET = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] esp,
    output logic        fault,
    input  logic        fault_clr
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned EW = 6;

    typedef enum logic [2:0] {IDLE, PUSH_WR, POP_RD, POP_CAP, RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic [EW-1:0] r_esp, w_esp_nxt, w_esp_dec, w_esp_inc, w_load_val;
    logic [DW-1:0] r_rsp_data, w_rsp_data_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic          r_cmd_ready;
    logic          w_fault_set;
    logic          w_push_bad, w_pop_bad, w_load_bad;

    // Pointer arithmetic wraps modulo DEPTH when unguarded; guard flags stop it first otherwise.
    assign w_esp_dec = (r_esp == '0) ? EW'(DEPTH - 1) : r_esp - EW'(1);
    assign w_esp_inc = EW'(r_esp[AW-1:0]) + EW'(1);

`ifdef STACK_GUARD_EN
    assign w_push_bad = (r_esp == '0);
    assign w_pop_bad  = (r_esp == EW'(DEPTH));
    assign w_load_bad = (cmd_data > DW'(DEPTH));
    assign w_load_val = cmd_data[EW-1:0];
`else
    assign w_push_bad = 1'b0;
    assign w_pop_bad  = 1'b0;
    assign w_load_bad = 1'b0;
    assign w_load_val = EW'(cmd_data[AW-1:0]);
`endif

    // Next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_esp_nxt       = r_esp;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_fault_set     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b01: begin
                            if (w_push_bad) begin
                                w_fault_set = 1'b1;
                            end else begin
                                w_esp_nxt       = w_esp_dec;
                                w_state_nxt     = PUSH_WR;
                                w_mem_we_nxt    = 1'b1;
                                w_mem_addr_nxt  = w_esp_dec[AW-1:0];
                                w_mem_wdata_nxt = cmd_data;
                            end
                        end
                        2'b10: begin
                            if (w_pop_bad) begin
                                w_fault_set     = 1'b1;
                                w_rsp_data_nxt  = '0;
                                w_rsp_valid_nxt = 1'b1;
                                w_state_nxt     = RESP;
                            end else begin
                                w_state_nxt    = POP_RD;
                                w_mem_addr_nxt = r_esp[AW-1:0];
                            end
                        end
                        2'b11: begin
                            if (w_load_bad) begin
                                w_fault_set = 1'b1;
                            end else begin
                                w_esp_nxt = w_load_val;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PUSH_WR: w_state_nxt = IDLE;
            POP_RD: begin
                w_esp_nxt   = w_esp_inc;
                w_state_nxt = POP_CAP;
            end
            POP_CAP: begin
                w_rsp_data_nxt  = mem_rdata;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_esp       <= EW'(ESP_RESET);
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_esp       <= w_esp_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
        end
    end

`ifdef STACK_GUARD_EN
    logic r_fault;

    // Sticky fault; a new fault in the same cycle beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_fault <= 1'b1;
        end else if (fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_fault;
    assign w_unused_fault = fault_clr | w_fault_set;
    assign fault          = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign esp       = DW'(r_esp);

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Directed bench for stack_port_ctrl with a synchronous-read memory model; covers both STACK_GUARD_EN builds.
module tb_stack_port_ctrl;
    logic        clk = 1'b0;
    logic        reset, cmd_valid, rsp_ready, fault_clr;
    logic        cmd_ready, rsp_valid, mem_we, fault;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data, rsp_data, mem_wdata, mem_rdata, esp;
    logic [4:0]  mem_addr;
    logic [31:0] mem [32];
    logic [31:0] d;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          we0;
    logic        saw;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] exp_rsp;
        logic [31:0] exp_esp;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    stack_port_ctrl #(.DEPTH(32), .ESP_RESET(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .esp(esp), .fault(fault), .fault_clr(fault_clr)
    );

    // Stack memory: write on strobe, read data registered one cycle after address.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] dat);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = dat;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 32'd0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_get(output logic [31:0] dat);
        issue(2'd2, 32'd0);
        wait_rsp();
        dat       = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'd1, 32'h0000_0011, 32'h0,          32'd30};
        vecs[1]  = '{2'd1, 32'h0000_0022, 32'h0,          32'd29};
        vecs[2]  = '{2'd2, 32'h0,         32'h0000_0022, 32'd30};
        vecs[3]  = '{2'd2, 32'h0,         32'h0000_0011, 32'd31};
        vecs[4]  = '{2'd2, 32'h0,         32'hDEAD_BEEF, 32'd32};
        vecs[5]  = '{2'd0, 32'h0000_1234, 32'h0,          32'd32};
        vecs[6]  = '{2'd3, 32'd5,         32'h0,          32'd5};
        vecs[7]  = '{2'd1, 32'hCAFE_0001, 32'h0,          32'd4};
        vecs[8]  = '{2'd2, 32'h0,         32'hCAFE_0001, 32'd5};
        vecs[9]  = '{2'd3, 32'd37,        32'h0,          32'd5};
        vecs[10] = '{2'd3, 32'd31,        32'h0,          32'd31};
        vecs[11] = '{2'd2, 32'h0,         32'hDEAD_BEEF, 32'd32};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0;
        rsp_ready = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_esp", esp, 32'd32);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        issue(2'd1, 32'hDEAD_BEEF);
        chk("push_we", 32'(mem_we), 32'd1);
        chk("push_addr", 32'(mem_addr), 32'd31);
        chk("push_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("push_esp", esp, 32'd31);
        chk("push_busy", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("push_we_end", 32'(mem_we), 32'd0);
        chk("push_addr_end", 32'(mem_addr), 32'd0);
        chk("push_ready_end", 32'(cmd_ready), 32'd1);
        chk("push_we_count", 32'(we_cnt), 32'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].op == 2'd2) begin
                pop_get(d);
                chk($sformatf("vec%0d_rsp", i), d, vecs[i].exp_rsp);
            end else begin
                issue(vecs[i].op, vecs[i].data);
                repeat (2) @(negedge clk);
            end
            chk($sformatf("vec%0d_esp", i), esp, vecs[i].exp_esp);
        end

`ifdef STACK_GUARD_EN
        chk("bad_load_fault", 32'(fault), 32'd1);
        pulse_clr();
        chk("fault_cleared", 32'(fault), 32'd0);
`else
        chk("fault_tied", 32'(fault), 32'd0);
`endif

        // Response held under back-pressure.
        issue(2'd1, 32'h0000_0077);
        repeat (2) @(negedge clk);
        issue(2'd2, 32'd0);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_data", k), rsp_data, 32'h0000_0077);
            chk($sformatf("stall%0d_ready", k), 32'(cmd_ready), 32'd0);
            chk($sformatf("stall%0d_addr", k), 32'(mem_addr), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("stall_release_ready", 32'(cmd_ready), 32'd1);
        chk("stall_release_valid", 32'(rsp_valid), 32'd0);
        chk("stall_esp", esp, 32'd32);

        // Reset while the pop read is in flight.
        issue(2'd1, 32'h0000_0055);
        repeat (2) @(negedge clk);
        we0 = we_cnt;
        issue(2'd2, 32'd0);
        chk("pop_rd_addr", 32'(mem_addr), 32'd31);
        chk("pop_rd_we", 32'(mem_we), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_esp", esp, 32'd32);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("abort_no_rsp", 32'(saw), 32'd0);
        chk("abort_no_we", 32'(we_cnt), 32'(we0));
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_esp_after", esp, 32'd32);

`ifdef STACK_GUARD_EN
        pop_get(d);
        chk("empty_pop_data", d, 32'd0);
        chk("empty_pop_fault", 32'(fault), 32'd1);
        chk("empty_pop_esp", esp, 32'd32);
        pulse_clr();
        chk("empty_pop_clr", 32'(fault), 32'd0);
        issue(2'd3, 32'd0);
        repeat (2) @(negedge clk);
        chk("load0_esp", esp, 32'd0);
        we0 = we_cnt;
        issue(2'd1, 32'h0000_0099);
        chk("full_push_we", 32'(mem_we), 32'd0);
        chk("full_push_fault", 32'(fault), 32'd1);
        chk("full_push_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("full_push_no_write", 32'(we_cnt), 32'(we0));
        chk("full_push_esp", esp, 32'd0);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 32'h0000_00AA; fault_clr = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0; fault_clr = 1'b0;
        chk("set_beats_clr", 32'(fault), 32'd1);
        pulse_clr();
        chk("clr_alone", 32'(fault), 32'd0);
        issue(2'd3, 32'd33);
        chk("load33_fault", 32'(fault), 32'd1);
        chk("load33_esp", esp, 32'd0);
`else
        issue(2'd3, 32'd1);
        repeat (2) @(negedge clk);
        chk("load1_esp", esp, 32'd1);
        issue(2'd1, 32'h0000_00A0);
        chk("push_idx0_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        chk("push_idx0_esp", esp, 32'd0);
        issue(2'd1, 32'h0000_00B0);
        chk("wrap_push_we", 32'(mem_we), 32'd1);
        chk("wrap_push_addr", 32'(mem_addr), 32'd31);
        chk("wrap_push_wdata", mem_wdata, 32'h0000_00B0);
        chk("wrap_push_esp", esp, 32'd31);
        pop_get(d);
        chk("wrap_pop1_data", d, 32'h0000_00B0);
        chk("wrap_pop1_esp", esp, 32'd32);
        pop_get(d);
        chk("wrap_pop2_data", d, 32'h0000_00A0);
        chk("wrap_pop2_esp", esp, 32'd1);
        chk("nofault", 32'(fault), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
